// File: rtl/seq_channel_mixer.sv
// seq_channel_mixer
// Time-multiplexed unsigned audio mixer. One shared adder walks the snapshot
// of all channels, one channel per clock, then applies the selected gain
// (auto-normalise, fixed shift or raw) and saturates to DATA_BITS.
module seq_channel_mixer #(
    parameter int DATA_BITS    = 12,
    parameter int NUM_CHANNELS = 12,
    parameter int FIXED_SHIFT  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_tick,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] din_flat,
    input  logic [NUM_CHANNELS-1:0]           ch_enable,
    input  logic [1:0]                        gain_mode,
    output logic [DATA_BITS-1:0]              dout,
    output logic                              dout_valid,
    output logic                              busy,
    output logic                              clipped,
    output logic                              overrun
);

    localparam int LOG_N    = $clog2(NUM_CHANNELS);
    localparam int ACC_BITS = DATA_BITS + LOG_N + 1;
    localparam int IDX_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_BITS = $clog2(NUM_CHANNELS + 1);
    localparam int SH_BITS  = $clog2(ACC_BITS + 1);
    localparam int FW       = NUM_CHANNELS * DATA_BITS;

    localparam logic [ACC_BITS-1:0] SAT_MAX  = {{(ACC_BITS-DATA_BITS){1'b0}}, {DATA_BITS{1'b1}}};
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                state_reg;
    logic [FW-1:0]         samp_flat_reg;
    logic [NUM_CHANNELS-1:0] en_reg;
    logic [1:0]            mode_reg;
    logic [ACC_BITS-1:0]   acc_reg;
    logic [CNT_BITS-1:0]   cnt_reg;
    logic [IDX_BITS-1:0]   idx_reg;
    logic [DATA_BITS-1:0]  dout_reg;
    logic                  valid_reg;
    logic                  busy_reg;
    logic                  clipped_reg;
    logic                  overrun_reg;

    logic [DATA_BITS-1:0]  samp_ch [NUM_CHANNELS];
    logic [DATA_BITS-1:0]  cur_samp;
    logic                  cur_en;
    logic [SH_BITS-1:0]    shift_next;
    logic [ACC_BITS-1:0]   res_next;

    // Smallest s with 2^s >= v; 0 and 1 both give 0.
    function automatic logic [SH_BITS-1:0] ceil_log2(input logic [CNT_BITS-1:0] v);
        logic [SH_BITS-1:0] r;
        r = '0;
        for (int s = 0; s <= CNT_BITS; s++) begin
            if ((32'd1 << s) < 32'(v)) begin
                r = SH_BITS'(s + 1);
            end
        end
        return r;
    endfunction

    // Split the snapshot bus into per-channel samples for the index mux.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
            assign samp_ch[gi] = samp_flat_reg[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    assign cur_samp = samp_ch[idx_reg];
    assign cur_en   = en_reg[idx_reg];

    // Gain stage: pick the shift from the captured mode, then shift logically.
    always_comb begin
        shift_next = '0;
        case (mode_reg)
            2'd1:    shift_next = SH_BITS'(FIXED_SHIFT);
            2'd2:    shift_next = '0;
            default: shift_next = ceil_log2(cnt_reg);
        endcase
        res_next = acc_reg >> shift_next;
    end

    // Mixer FSM: capture on tick, accumulate one channel per cycle, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            samp_flat_reg <= '0;
            en_reg        <= '0;
            mode_reg      <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            dout_reg      <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            clipped_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (sample_tick) begin
                        samp_flat_reg <= din_flat;
                        en_reg        <= ch_enable;
                        mode_reg      <= gain_mode;
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        idx_reg       <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (sample_tick) begin
                        overrun_reg <= 1'b1;
                    end
                    if (cur_en) begin
                        acc_reg <= acc_reg + ACC_BITS'(cur_samp);
                        cnt_reg <= cnt_reg + CNT_BITS'(1);
                    end
                    idx_reg <= idx_reg + IDX_BITS'(1);
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (sample_tick) begin
                        overrun_reg <= 1'b1;
                    end
                    if (res_next > SAT_MAX) begin
                        dout_reg    <= {DATA_BITS{1'b1}};
                        clipped_reg <= 1'b1;
                    end else begin
                        dout_reg    <= res_next[DATA_BITS-1:0];
                        clipped_reg <= 1'b0;
                    end
                    valid_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;
    assign busy       = busy_reg;
    assign clipped    = clipped_reg;
    assign overrun    = overrun_reg;

endmodule
